// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-128 inverse-cipher sequencing controller.
//   NR           : number of datapath passes per block
//   LAST_KEY_IDX : round-key index used by the initial AddRoundKey
//   BLOCK_W      : state / block width in bits
//   aes_state_e  : controller FSM states
// -----------------------------------------------------------------------------
package aes_pkg;
  localparam int         NR           = 10;
  localparam logic [3:0] LAST_KEY_IDX = 4'd10;
  localparam int         BLOCK_W      = 128;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN,
    DONE
  } aes_state_e;
endpackage

// File: rtl/aes_dec_round_ctrl_if.sv
// -----------------------------------------------------------------------------
// aes_dec_round_ctrl_if
// Block-level handshakes of the inverse-cipher controller.
//   in_valid/in_ready/in_block    : ciphertext input, byte 0 at [127:120]
//   out_valid/out_ready/out_block : plaintext output
// Modports:
//   master : producer of ciphertext and consumer of plaintext
//   slave  : the controller
// -----------------------------------------------------------------------------
interface aes_dec_round_ctrl_if;
  import aes_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] in_block;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_block;

  modport master (
    output in_valid, in_block, out_ready,
    input  in_ready, out_valid, out_block
  );

  modport slave (
    input  in_valid, in_block, out_ready,
    output in_ready, out_valid, out_block
  );
endinterface

// File: rtl/aes_dec_round_timer.sv
// -----------------------------------------------------------------------------
// aes_dec_round_timer
// Waits out the fixed latency of one external datapath pass.
//   clk   : system clock
//   rst   : synchronous active-high reset, clears the count
//   start : one-cycle launch pulse (same cycle as dp_go)
//   done  : high in the cycle DP_LAT cycles after start, when dp_out is valid
// -----------------------------------------------------------------------------
module aes_dec_round_timer #(
  parameter int DP_LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);
  localparam logic [3:0] LAT = 4'(DP_LAT);

  // Zero means idle; otherwise the count is the number of cycles since start.
  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (start) begin
      cnt_q <= 4'd1;
    end else if (done) begin
      cnt_q <= 4'd0;
    end else if (cnt_q != 4'd0) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign done = (cnt_q == LAT);
endmodule

// File: rtl/aes_dec_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_dec_round_ctrl
// Sequencing controller for the AES-128 inverse cipher. Accepts a ciphertext
// block, applies the initial AddRoundKey (key 10), then drives ten passes
// through an external inverse-round datapath (keys 9..0, InvMixColumns
// bypassed on the last pass) and returns the plaintext.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : in/out valid-ready block handshakes (slave side)
//   rk_idx    : round-key index to the key store (10 down to 0)
//   rk        : round key for rk_idx, same cycle
//   dp_go     : one-cycle pass launch pulse
//   dp_in     : state to the datapath, stable for a whole pass
//   dp_key    : round key to the datapath (= rk)
//   dp_last   : final pass, datapath skips InvMixColumns
//   dp_out    : datapath result, valid DP_LAT cycles after dp_go
//   busy      : high in every state except IDLE
// Optional (macro AES_DEC_PERF_CNT_EN):
//   blk_cnt   : output transfers, wrapping
//   stall_cnt : DONE cycles with out_ready low, saturating
// -----------------------------------------------------------------------------
module aes_dec_round_ctrl
  import aes_pkg::*;
#(
  parameter int DP_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  aes_dec_round_ctrl_if.slave bus,
  output logic [3:0]         rk_idx,
  input  logic [BLOCK_W-1:0] rk,
  output logic               dp_go,
  output logic [BLOCK_W-1:0] dp_in,
  output logic [BLOCK_W-1:0] dp_key,
  output logic               dp_last,
  input  logic [BLOCK_W-1:0] dp_out,
  output logic               busy
`ifdef AES_DEC_PERF_CNT_EN
  ,
  output logic [31:0]        blk_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  aes_state_e         fsm_q, fsm_d;
  logic [BLOCK_W-1:0] state_q;
  logic               launch_q;
  logic               pass_done;

  aes_dec_round_timer #(.DP_LAT(DP_LAT)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (launch_q),
    .done  (pass_done)
  );

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE: if (bus.in_valid) fsm_d = INIT;
      INIT: fsm_d = RUN;
      RUN:  if (pass_done && rk_idx == 4'd0) fsm_d = DONE;
      DONE: if (bus.out_ready) fsm_d = IDLE;
    endcase
  end

  // launch_q is the first cycle of a pass; state_q only changes at pass end,
  // so dp_in stays stable while the datapath works on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= '0;
      rk_idx   <= LAST_KEY_IDX;
      launch_q <= 1'b0;
    end else begin
      launch_q <= 1'b0;
      unique case (fsm_q)
        IDLE: if (bus.in_valid) state_q <= bus.in_block;
        INIT: begin
          state_q  <= state_q ^ rk;
          rk_idx   <= 4'(NR - 1);
          launch_q <= 1'b1;
        end
        RUN: if (pass_done) begin
          state_q <= dp_out;
          if (rk_idx != 4'd0) begin
            rk_idx   <= rk_idx - 4'd1;
            launch_q <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) rk_idx <= LAST_KEY_IDX;
      endcase
    end
  end

  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.out_block = (fsm_q == DONE) ? state_q : '0;
  assign busy          = (fsm_q != IDLE);
  assign dp_go         = launch_q;
  assign dp_in         = state_q;
  assign dp_key        = rk;
  assign dp_last       = (fsm_q == RUN) && (rk_idx == 4'd0);

`ifdef AES_DEC_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt   <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (fsm_q == DONE && bus.out_ready)  blk_cnt   <= blk_cnt + 32'd1;
      if (fsm_q == DONE && !bus.out_ready) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
module tb_aes_dec_round_ctrl;
  import aes_pkg::*;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] X2_CT   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] GARBAGE = {4{32'hdeadbeef}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [7:0]   sbox   [256];
  logic [7:0]   isbox  [256];
  logic [127:0] rkeys  [16];

  // ---------------- instance A (DP_LAT=3) ----------------
  aes_dec_round_ctrl_if bus_a ();
  logic [3:0]   rk_idx_a;
  logic [127:0] rk_a, dp_in_a, dp_key_a, dp_out_a;
  logic         dp_go_a, dp_last_a, busy_a;
  logic [127:0] pipe_a [LAT_A];
  // ---------------- instance B (DP_LAT=1) ----------------
  aes_dec_round_ctrl_if bus_b ();
  logic [3:0]   rk_idx_b;
  logic [127:0] rk_b, dp_in_b, dp_key_b, dp_out_b;
  logic         dp_go_b, dp_last_b, busy_b;
  logic [127:0] pipe_b [LAT_B];
`ifdef AES_DEC_PERF_CNT_EN
  logic [31:0] blk_cnt_a, stall_cnt_a, blk_cnt_b, stall_cnt_b;
`endif

  assign rk_a = rkeys[rk_idx_a];
  assign rk_b = rkeys[rk_idx_b];

  aes_dec_round_ctrl #(.DP_LAT(LAT_A)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .rk_idx(rk_idx_a), .rk(rk_a),
    .dp_go(dp_go_a), .dp_in(dp_in_a), .dp_key(dp_key_a), .dp_last(dp_last_a),
    .dp_out(dp_out_a), .busy(busy_a)
`ifdef AES_DEC_PERF_CNT_EN
    , .blk_cnt(blk_cnt_a), .stall_cnt(stall_cnt_a)
`endif
  );

  aes_dec_round_ctrl #(.DP_LAT(LAT_B)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .rk_idx(rk_idx_b), .rk(rk_b),
    .dp_go(dp_go_b), .dp_in(dp_in_b), .dp_key(dp_key_b), .dp_last(dp_last_b),
    .dp_out(dp_out_b), .busy(busy_b)
`ifdef AES_DEC_PERF_CNT_EN
    , .blk_cnt(blk_cnt_b), .stall_cnt(stall_cnt_b)
`endif
  );

  // ---------------- AES reference pieces ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        b[rr+4*c] = isbox[a[rr + 4*((c - rr + 4) % 4)]] ^ k[127-8*(rr+4*c) -: 8];
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int rr = 0; rr < 4; rr++) a[rr+4*c] = b[rr+4*c];
      end else begin
        a[4*c+0] = gmul(b[4*c],8'h0e) ^ gmul(b[4*c+1],8'h0b) ^ gmul(b[4*c+2],8'h0d) ^ gmul(b[4*c+3],8'h09);
        a[4*c+1] = gmul(b[4*c],8'h09) ^ gmul(b[4*c+1],8'h0e) ^ gmul(b[4*c+2],8'h0b) ^ gmul(b[4*c+3],8'h0d);
        a[4*c+2] = gmul(b[4*c],8'h0d) ^ gmul(b[4*c+1],8'h09) ^ gmul(b[4*c+2],8'h0e) ^ gmul(b[4*c+3],8'h0b);
        a[4*c+3] = gmul(b[4*c],8'h0b) ^ gmul(b[4*c+1],8'h0d) ^ gmul(b[4*c+2],8'h09) ^ gmul(b[4*c+3],8'h0e);
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = a[i];
    return r;
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rkeys[10];
    for (int r = 9; r >= 1; r--) s = inv_round(s, rkeys[r], 1'b0);
    return inv_round(s, rkeys[0], 1'b1);
  endfunction

  task automatic build_tables();
    logic [7:0]  inv, xb, s, rcon;
    logic [31:0] w [44];
    logic [31:0] t;
    logic [127:0] key;
    for (int x = 0; x < 256; x++) begin
      xb = 8'(x);
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++) if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv,1) ^ rotl8(inv,2) ^ rotl8(inv,3) ^ rotl8(inv,4) ^ 8'h63;
      sbox[x] = s;
      isbox[s] = xb;
    end
    key = 128'h000102030405060708090a0b0c0d0e0f;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rkeys[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // External datapath models: real result only for a launched pass.
  always @(posedge clk) begin
    pipe_a[0] <= dp_go_a ? inv_round(dp_in_a, dp_key_a, dp_last_a) : GARBAGE;
    for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
  end
  assign dp_out_a = pipe_a[LAT_A-1];

  always @(posedge clk) begin
    pipe_b[0] <= dp_go_b ? inv_round(dp_in_b, dp_key_b, dp_last_b) : GARBAGE;
  end
  assign dp_out_b = pipe_b[LAT_B-1];

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic send_a(input logic [127:0] blk, output logic ok);
    ok = 1'b0;
    bus_a.in_valid = 1'b1;
    bus_a.in_block = blk;
    for (int i = 0; i < 200; i++) begin
      if (bus_a.in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus_a.in_valid = 1'b0;
  endtask

  task automatic run_a(input logic [127:0] blk, input int stall, output logic [127:0] res,
                       output int lat, output logic ok);
    logic sent;
    send_a(blk, sent);
    lat = 1; ok = 1'b0; res = '0;
    for (int i = 0; i < 300; i++) begin
      if (bus_a.out_valid) begin ok = sent; break; end
      @(negedge clk);
      lat++;
    end
    repeat (stall) @(negedge clk);
    res = bus_a.out_block;
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus_a.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus_a.in_ready); end
    checks++; if (bus_a.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus_a.out_valid); end
    checks++; if (bus_a.out_block !== 128'h0) begin fails++; $display("FAIL reset_out_block: got %h want 0", bus_a.out_block); end
    checks++; if (dp_go_a !== 1'b0) begin fails++; $display("FAIL reset_dp_go: got %b want 0", dp_go_a); end
    checks++; if (dp_last_a !== 1'b0) begin fails++; $display("FAIL reset_dp_last: got %b want 0", dp_last_a); end
    checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (rk_idx_a !== 4'd10) begin fails++; $display("FAIL reset_rk_idx: got %0d want 10", rk_idx_a); end
    checks++; if (dp_in_a !== 128'h0) begin fails++; $display("FAIL reset_state: got %h want 0", dp_in_a); end
    checks++; if (bus_b.in_ready !== 1'b1 || busy_b !== 1'b0 || rk_idx_b !== 4'd10) begin
      fails++; $display("FAIL reset_b: got ready=%b busy=%b rk_idx=%0d want 1 0 10", bus_b.in_ready, busy_b, rk_idx_b); end
`ifdef AES_DEC_PERF_CNT_EN
    checks++; if (blk_cnt_a !== 32'd0 || stall_cnt_a !== 32'd0 || blk_cnt_b !== 32'd0 || stall_cnt_b !== 32'd0) begin
      fails++; $display("FAIL reset_cnt: got blk=%0d stall=%0d want 0 0", blk_cnt_a, stall_cnt_a); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_c1();
    logic sent;
    int gocnt, first_ov;
    logic [127:0] go_in;
    send_a(C1_CT, sent);
    checks++; if (sent !== 1'b1) begin fails++; $display("FAIL c1_accept: got %b want 1", sent); end
    gocnt = 0; first_ov = 0; go_in = '0;
    for (int n = 1; n <= 45; n++) begin
      if (n == 1) begin
        checks++; if (rk_idx_a !== 4'd10 || dp_key_a !== rkeys[10]) begin
          fails++; $display("FAIL c1_init_key: got idx=%0d key=%h want 10 %h", rk_idx_a, dp_key_a, rkeys[10]); end
        checks++; if (busy_a !== 1'b1 || bus_a.in_ready !== 1'b0) begin
          fails++; $display("FAIL c1_init_busy: got busy=%b ready=%b want 1 0", busy_a, bus_a.in_ready); end
      end
      if (dp_go_a) begin
        checks++;
        if (n != 2 + gocnt*(LAT_A+1) || rk_idx_a !== 4'(9 - gocnt) || dp_last_a !== (gocnt == 9) ||
            dp_key_a !== rkeys[9 - gocnt]) begin
          fails++; $display("FAIL c1_pass%0d: got cycle=%0d idx=%0d last=%b want cycle=%0d idx=%0d last=%b",
                            gocnt, n, rk_idx_a, dp_last_a, 2 + gocnt*(LAT_A+1), 9 - gocnt, gocnt == 9);
        end
        gocnt++;
        go_in = dp_in_a;
      end else if (n >= 2 && n < 42) begin
        checks++; if (dp_in_a !== go_in) begin fails++; $display("FAIL c1_dp_in_hold@%0d: got %h want %h", n, dp_in_a, go_in); end
      end
      checks++; if (dp_last_a !== (n >= 38 && n < 42)) begin fails++; $display("FAIL c1_dp_last@%0d: got %b want %b", n, dp_last_a, n >= 38 && n < 42); end
      checks++; if (bus_a.out_valid !== (n >= 42)) begin fails++; $display("FAIL c1_out_valid@%0d: got %b want %b", n, bus_a.out_valid, n >= 42); end
      if (bus_a.out_valid && first_ov == 0) first_ov = n;
      @(negedge clk);
    end
    checks++; if (gocnt != 10) begin fails++; $display("FAIL c1_go_count: got %0d want 10", gocnt); end
    checks++; if (first_ov != 42) begin fails++; $display("FAIL c1_latency: got %0d want 42", first_ov); end
    checks++; if (bus_a.out_block !== C1_PT) begin fails++; $display("FAIL c1_plaintext: got %h want %h", bus_a.out_block, C1_PT); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 20; i++) begin
      checks++; if (bus_a.out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid@%0d: got %b want 1", i, bus_a.out_valid); end
      checks++; if (bus_a.out_block !== C1_PT) begin fails++; $display("FAIL bp_block@%0d: got %h want %h", i, bus_a.out_block, C1_PT); end
      checks++; if (bus_a.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready@%0d: got %b want 0", i, bus_a.in_ready); end
      @(negedge clk);
    end
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.out_ready = 1'b0;
    checks++; if (bus_a.out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %b want 0", bus_a.out_valid); end
    checks++; if (bus_a.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready: got %b want 1", bus_a.in_ready); end
    checks++; if (rk_idx_a !== 4'd10 || busy_a !== 1'b0) begin
      fails++; $display("FAIL bp_release_idle: got idx=%0d busy=%b want 10 0", rk_idx_a, busy_a); end
  endtask

  task automatic test_reset_mid();
    logic sent, ok;
    logic [127:0] res;
    int cnt, lat;
    send_a(C1_CT, sent);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (dp_go_a) cnt++;
      if (cnt == 5) break;
      @(negedge clk);
    end
    checks++; if (cnt != 5) begin fails++; $display("FAIL rmid_fifth_go: got %0d pulses want 5", cnt); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy_a !== 1'b0 || bus_a.in_ready !== 1'b1) begin
      fails++; $display("FAIL rmid_idle: got busy=%b ready=%b want 0 1", busy_a, bus_a.in_ready); end
    checks++; if (rk_idx_a !== 4'd10) begin fails++; $display("FAIL rmid_rk_idx: got %0d want 10", rk_idx_a); end
    checks++; if (bus_a.out_valid !== 1'b0 || dp_go_a !== 1'b0) begin
      fails++; $display("FAIL rmid_outputs: got valid=%b go=%b want 0 0", bus_a.out_valid, dp_go_a); end
    run_a(C1_CT, 0, res, lat, ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL rmid_timeout: got ok=%b want 1", ok); end
    checks++; if (res !== C1_PT) begin fails++; $display("FAIL rmid_plaintext: got %h want %h", res, C1_PT); end
    checks++; if (lat != 42) begin fails++; $display("FAIL rmid_latency: got %0d want 42", lat); end
  endtask

  task automatic test_back_to_back();
    int acc [2];
    int outc [2];
    logic [127:0] outb [2];
    int na, no;
    acc[0] = 0; acc[1] = 0; outc[0] = 0; outc[1] = 0; outb[0] = '0; outb[1] = '0;
    na = 0; no = 0;
    bus_b.out_ready = 1'b1;
    bus_b.in_valid  = 1'b1;
    bus_b.in_block  = C1_CT;
    for (int n = 0; n < 120 && no < 2; n++) begin
      if (bus_b.in_valid && bus_b.in_ready) begin
        if (na < 2) acc[na] = n;
        na++;
      end
      if (bus_b.out_valid) begin
        if (no < 2) begin outc[no] = n; outb[no] = bus_b.out_block; end
        no++;
      end
      @(negedge clk);
      if (na == 1) bus_b.in_block = X2_CT;
      if (na >= 2) bus_b.in_valid = 1'b0;
    end
    bus_b.in_valid  = 1'b0;
    bus_b.out_ready = 1'b0;
    checks++; if (na != 2 || no != 2) begin fails++; $display("FAIL b2b_counts: got acc=%0d out=%0d want 2 2", na, no); end
    checks++; if (acc[1] - acc[0] != 23) begin fails++; $display("FAIL b2b_accept_gap: got %0d want 23", acc[1] - acc[0]); end
    checks++; if (outc[0] - acc[0] != 22) begin fails++; $display("FAIL b2b_latency: got %0d want 22", outc[0] - acc[0]); end
    checks++; if (outc[1] - outc[0] != 23) begin fails++; $display("FAIL b2b_out_gap: got %0d want 23", outc[1] - outc[0]); end
    checks++; if (outb[0] !== C1_PT) begin fails++; $display("FAIL b2b_block0: got %h want %h", outb[0], C1_PT); end
    checks++; if (outb[1] !== ref_decrypt(X2_CT)) begin fails++; $display("FAIL b2b_block1: got %h want %h", outb[1], ref_decrypt(X2_CT)); end
  endtask

`ifdef AES_DEC_PERF_CNT_EN
  task automatic test_perf();
    logic ok0, ok1, ok2;
    logic [127:0] r0, r1, r2;
    int lat;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_a(C1_CT, 5, r0, lat, ok0);
    run_a(X2_CT, 0, r1, lat, ok1);
    run_a(C1_CT, 0, r2, lat, ok2);
    checks++; if (!(ok0 && ok1 && ok2) || r0 !== C1_PT || r1 !== ref_decrypt(X2_CT) || r2 !== C1_PT) begin
      fails++; $display("FAIL perf_blocks: got %h %h %h", r0, r1, r2); end
    checks++; if (blk_cnt_a !== 32'd3) begin fails++; $display("FAIL perf_blk_cnt: got %0d want 3", blk_cnt_a); end
    checks++; if (stall_cnt_a !== 32'd5) begin fails++; $display("FAIL perf_stall_cnt: got %0d want 5", stall_cnt_a); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_block = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_block = '0; bus_b.out_ready = 1'b0;
    build_tables();
    test_reset();
    test_c1();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef AES_DEC_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
